// File: rtl/morse_pkg.sv
// Shared Morse definitions used by the input capture and output (transmit) blocks.
package morse_pkg;

    localparam int unsigned MORSE_CODE_W  = 5;
    localparam int unsigned MORSE_LEN_W   = 3;
    localparam int unsigned MORSE_MAX_LEN = 5;

    localparam logic MORSE_DOT  = 1'b0;
    localparam logic MORSE_DASH = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_MARK,
        TX_SPACE,
        TX_CHAR_GAP
    } tx_state_e;

    // Symbol idx of an MSB-first code (symbol 0 lives in the top bit).
    function automatic logic morse_sym(input logic [MORSE_CODE_W-1:0] code,
                                       input logic [MORSE_LEN_W-1:0]  idx);
        logic [MORSE_CODE_W-1:0] shifted;
        shifted = code << idx;
        return shifted[MORSE_CODE_W-1];
    endfunction

    // A character length is playable when it is 1..MORSE_MAX_LEN.
    function automatic logic morse_len_ok(input logic [MORSE_LEN_W-1:0] len);
        return (len != '0) && (len <= MORSE_LEN_W'(MORSE_MAX_LEN));
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Phase timer: prescaler of UNIT_CYCLES clocks feeding a unit counter.
// phase_done is high in the last clock of a target_units-long phase.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned UNIT_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [UNIT_W-1:0] target_units,
    output logic              phase_done
);

    localparam int unsigned PRESC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [UNIT_W-1:0]  units_q, units_d;
    logic               unit_end;

    assign unit_end   = (presc_q == PRESC_W'(UNIT_CYCLES - 1));
    assign phase_done = unit_end && (units_q == (target_units - UNIT_W'(1)));

    // Next counter values; restart pins both counters to zero.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        units_d = units_q;
        if (restart) begin
            presc_d = '0;
            units_d = '0;
        end else if (unit_end) begin
            presc_d = '0;
            units_d = phase_done ? '0 : units_q + UNIT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            units_q <= '0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/morse_output_fsm.sv
// Morse transmitter: plays one latched character as timed marks and spaces.
module morse_output_fsm
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES    = 4,
    parameter int unsigned DASH_UNITS     = 3,
    parameter int unsigned SYM_GAP_UNITS  = 1,
    parameter int unsigned CHAR_GAP_UNITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MORSE_CODE_W-1:0] morse_code,
    input  logic [MORSE_LEN_W-1:0]  morse_len,
    input  logic                    abort,
    output logic                    tone,
    output logic                    busy,
    output logic                    done,
    output logic [MORSE_LEN_W-1:0]  sym_idx
);

    localparam int unsigned MAX_A     = (DASH_UNITS > SYM_GAP_UNITS) ? DASH_UNITS : SYM_GAP_UNITS;
    localparam int unsigned MAX_B     = (MAX_A > CHAR_GAP_UNITS) ? MAX_A : CHAR_GAP_UNITS;
    localparam int unsigned MAX_UNITS = (MAX_B > 1) ? MAX_B : 1;
    localparam int unsigned UNIT_W    = $clog2(MAX_UNITS + 1);

    tx_state_e               state_q, state_d;
    logic [MORSE_CODE_W-1:0] code_q, code_d;
    logic [MORSE_LEN_W-1:0]  len_q, len_d;
    logic [MORSE_LEN_W-1:0]  sym_idx_q, sym_idx_d;
    logic                    tone_q, tone_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [UNIT_W-1:0]       target_units_c;
    logic                    restart_c;
    logic                    phase_done;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .UNIT_W      (UNIT_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart_c),
        .target_units (target_units_c),
        .phase_done   (phase_done)
    );

    // Next state, latched character, phase length and registered outputs.
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        len_d          = len_q;
        sym_idx_d      = sym_idx_q;
        done_d         = 1'b0;
        target_units_c = UNIT_W'(1);

        case (state_q)
            TX_IDLE: begin
                if (start && !abort && morse_len_ok(morse_len)) begin
                    state_d   = TX_MARK;
                    code_d    = morse_code;
                    len_d     = morse_len;
                    sym_idx_d = '0;
                end
            end
            TX_MARK: begin
                target_units_c = (morse_sym(code_q, sym_idx_q) == MORSE_DASH)
                               ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
                if (abort) begin
                    state_d   = TX_IDLE;
                    sym_idx_d = '0;
                end else if (phase_done) begin
                    state_d = (sym_idx_q == (len_q - MORSE_LEN_W'(1))) ? TX_CHAR_GAP : TX_SPACE;
                end
            end
            TX_SPACE: begin
                target_units_c = UNIT_W'(SYM_GAP_UNITS);
                if (abort) begin
                    state_d   = TX_IDLE;
                    sym_idx_d = '0;
                end else if (phase_done) begin
                    state_d   = TX_MARK;
                    sym_idx_d = sym_idx_q + MORSE_LEN_W'(1);
                end
            end
            TX_CHAR_GAP: begin
                target_units_c = UNIT_W'(CHAR_GAP_UNITS);
                if (abort) begin
                    state_d   = TX_IDLE;
                    sym_idx_d = '0;
                end else if (phase_done) begin
                    state_d = TX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = TX_IDLE;
                sym_idx_d = '0;
            end
        endcase

        // Every state entry starts a fresh phase; IDLE keeps the timer cleared.
        restart_c = (state_d != state_q) || (state_d == TX_IDLE);
        tone_d    = (state_d == TX_MARK);
        busy_d    = (state_d != TX_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            code_q    <= '0;
            len_q     <= '0;
            sym_idx_q <= '0;
            tone_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            len_q     <= len_d;
            sym_idx_q <= sym_idx_d;
            tone_q    <= tone_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tone    = tone_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sym_idx = sym_idx_q;

endmodule

// File: tb/tb_morse_output_fsm.sv
// Scoreboard bench for morse_output_fsm: stimulus queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_morse_output_fsm;

    localparam int U    = 4;
    localparam int DASH = 3;
    localparam int SYM  = 1;
    localparam int CHR  = 3;

    typedef struct {
        logic       tone;
        logic       busy;
        logic       done;
        logic [2:0] idx;
        int         tag;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] morse_code;
    logic [2:0] morse_len;
    logic       abort;
    logic       tone;
    logic       busy;
    logic       done;
    logic [2:0] sym_idx;

    rec_t       exp_q[$];
    rec_t       mon_r;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cur_tag  = 0;
    logic [2:0] last_idx = 3'd0;

    morse_output_fsm #(
        .UNIT_CYCLES    (U),
        .DASH_UNITS     (DASH),
        .SYM_GAP_UNITS  (SYM),
        .CHAR_GAP_UNITS (CHR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .morse_code (morse_code),
        .morse_len  (morse_len),
        .abort      (abort),
        .tone       (tone),
        .busy       (busy),
        .done       (done),
        .sym_idx    (sym_idx)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per cycle while the scoreboard holds any.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_r = exp_q.pop_front();
            n_checks++;
            if ({tone, busy, done, sym_idx} !== {mon_r.tone, mon_r.busy, mon_r.done, mon_r.idx}) begin
                n_fail++;
                $display("FAIL test%0d trace @%0t: tone/busy/done/idx got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         mon_r.tag, $time, tone, busy, done, sym_idx,
                         mon_r.tone, mon_r.busy, mon_r.done, mon_r.idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic t, input logic b, input logic d,
                            input logic [2:0] i, input int n);
        rec_t r;
        r.tone = t; r.busy = b; r.done = d; r.idx = i; r.tag = cur_tag;
        for (int k = 0; k < n; k++) exp_q.push_back(r);
    endtask

    task automatic push_idle(input int n);
        push_run(1'b0, 1'b0, 1'b0, last_idx, n);
    endtask

    // Expected trace from the cycle after accept through the done cycle.
    task automatic push_char(input logic [4:0] code, input int len);
        logic [4:0] c;
        c = code;
        for (int i = 0; i < len; i++) begin
            push_run(1'b1, 1'b1, 1'b0, 3'(i), c[4-i] ? DASH * U : U);
            if (i < len - 1) push_run(1'b0, 1'b1, 1'b0, 3'(i), SYM * U);
        end
        push_run(1'b0, 1'b1, 1'b0, 3'(len - 1), CHR * U);
        push_run(1'b0, 1'b0, 1'b1, 3'(len - 1), 1);
        last_idx = 3'(len - 1);
    endtask

    task automatic wait_qsize(input int k);
        int n;
        n = 0;
        while (exp_q.size() > k) begin
            step();
            n++;
            if (n > 2000) begin
                $display("FAIL scoreboard_wait: queue size %0d required %0d", exp_q.size(), k);
                $fatal(1, "scoreboard did not drain");
            end
        end
    endtask

    // Present a character in the current (idle) cycle for one clock.
    task automatic send(input logic [4:0] code, input logic [2:0] len);
        push_idle(1);
        start      = 1'b1;
        morse_code = code;
        morse_len  = len;
        push_char(code, int'(len));
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; morse_code = '0; morse_len = '0; abort = 1'b0;

        // Reset values.
        cur_tag = 0;
        push_idle(3);
        step(); step();
        rst_n = 1'b1;
        wait_qsize(0);

        // 'E': 4 on, 12 off, done at cycle 17.
        cur_tag = 1;
        send(5'b00000, 3'd1);
        wait_qsize(0);

        // 'A': dot, space, dash, gap.
        cur_tag = 2;
        send(5'b01000, 3'd2);
        wait_qsize(0);

        // '0': five dashes; a mid-character start with other inputs is ignored.
        cur_tag = 3;
        send(5'b11111, 3'd5);
        repeat (9) step();
        start = 1'b1; morse_code = 5'b00000; morse_len = 3'd1;
        step(); step();
        start = 1'b0; morse_len = 3'd0;
        wait_qsize(0);

        // Illegal lengths and start+abort in IDLE are ignored.
        cur_tag = 4;
        push_idle(5);
        start = 1'b1; morse_code = 5'b10000; morse_len = 3'd0;
        step();
        morse_len = 3'd7;
        step();
        morse_len = 3'd1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        wait_qsize(0);

        // Abort mid-dash of 'T' in cycle 6, then replay it in full.
        cur_tag = 5;
        push_idle(1);
        start = 1'b1; morse_code = 5'b10000; morse_len = 3'd1;
        push_run(1'b1, 1'b1, 1'b0, 3'd0, 6);
        push_run(1'b0, 1'b0, 1'b0, 3'd0, 2);
        last_idx = 3'd0;
        step();
        start = 1'b0;
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_qsize(0);
        cur_tag = 6;
        send(5'b10000, 3'd1);
        wait_qsize(0);

        // Back-to-back 'E': second start issued in the done cycle.
        cur_tag = 7;
        send(5'b00000, 3'd1);
        wait_qsize(1);
        start = 1'b1; morse_code = 5'b00000; morse_len = 3'd1;
        push_char(5'b00000, 1);
        step();
        start = 1'b0;
        wait_qsize(0);

        // Async reset mid-mark: outputs clear before the next clock edge.
        cur_tag = 8;
        push_idle(1);
        start = 1'b1; morse_code = 5'b10000; morse_len = 3'd1;
        push_run(1'b1, 1'b1, 1'b0, 3'd0, 2);
        step();
        start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        last_idx = 3'd0;
        push_idle(4);
        step(); step();
        rst_n = 1'b1;
        wait_qsize(0);

        // Recovery after reset: a normal 'A'.
        cur_tag = 9;
        send(5'b01000, 3'd2);
        wait_qsize(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
